// File: rtl/nos_dac_sequencer_if.sv
// Stereo sample stream from the I2S receive side into the DAC frame sequencer.
// Valid/ready: a word transfers on any clk edge where s_valid and s_ready are both high.
interface nos_dac_sequencer_if #(
    parameter int W = 48
) ();
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/nos_dac_sequencer.sv
// Frame scheduler for the NOS DAC FULL-mode shifter: sample FIFO, one start pulse per
// frame, frame-aligned configuration, priming, underrun handling and end-of-frame stop.
module nos_dac_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int FRAME_CLKS  = 64,
    parameter int UCNT_W      = 16,
    parameter int I2S_BITS    = 24,
    parameter int NOS_BITNUM  = 2
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    underrun_mode,
    input  logic [NOS_BITNUM-1:0]   cfg_nos_bitnum,
    input  logic                    cfg_bck_cont,
    nos_dac_sequencer_if.slave      s_if,
    output logic [I2S_BITS*2-1:0]   dac_data,
    output logic                    dac_start,
    output logic [NOS_BITNUM-1:0]   dac_nos_bitnum,
    output logic                    dac_bck_cont,
    output logic                    running,
    output logic [UCNT_W-1:0]       underrun_cnt,
    input  logic                    underrun_clr,
    output logic                    dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FRAME_CLKS);
    localparam int DW = I2S_BITS * 2;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t                r_state;
    logic [DW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_fill;
    logic                  r_s_ready;
    logic [FW-1:0]         r_fcnt;
    logic [DW-1:0]         r_dac_data;
    logic                  r_dac_start;
    logic [NOS_BITNUM-1:0] r_dac_nos_bitnum;
    logic                  r_dac_bck_cont;
    logic                  r_running;
    logic [UCNT_W-1:0]     r_underrun_cnt;

    state_t                w_state_next;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start_next;
    logic                  w_underrun;
    logic                  w_stop;
    logic                  w_wrap;
    logic [AW:0]           w_fill_next;

    assign w_push      = s_if.s_valid & r_s_ready;
    assign w_wrap      = (r_state == S_RUN) && (r_fcnt == FW'(FRAME_CLKS - 1));
    assign w_fill_next = r_fill + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_start_next = 1'b0;
        w_underrun   = 1'b0;
        w_stop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && (r_fill >= (AW + 1)'(PRIME_LEVEL))) begin
                    w_state_next = S_RUN;
                    w_pop        = 1'b1;
                    w_start_next = 1'b1;
                end
            end
            S_RUN: begin
                // Stop is only honoured at the wrap so a frame is never cut short.
                if (w_wrap) begin
                    if (!enable) begin
                        w_state_next = S_IDLE;
                        w_stop       = 1'b1;
                    end else begin
                        w_start_next = 1'b1;
                        if (r_fill == '0) w_underrun = 1'b1;
                        else              w_pop      = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_fill           <= '0;
            r_s_ready        <= 1'b1;
            r_fcnt           <= '0;
            r_dac_data       <= '0;
            r_dac_start      <= 1'b0;
            r_dac_nos_bitnum <= '0;
            r_dac_bck_cont   <= 1'b0;
            r_running        <= 1'b0;
            r_underrun_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_running   <= (w_state_next == S_RUN);
            r_dac_start <= w_start_next;
            r_fill      <= w_fill_next;
            r_s_ready   <= (w_fill_next < (AW + 1)'(FIFO_DEPTH));
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;

            if ((r_state == S_RUN) && !w_wrap) r_fcnt <= r_fcnt + 1'b1;
            else                               r_fcnt <= '0;

            if (w_pop)                            r_dac_data <= r_mem[r_rptr];
            else if (w_underrun && !underrun_mode) r_dac_data <= '0;
            else if (w_stop)                       r_dac_data <= '0;

            // Config follows the inputs freely in IDLE; in RUN it only moves on the wrap.
            if ((r_state == S_IDLE) || w_wrap) begin
                r_dac_nos_bitnum <= cfg_nos_bitnum;
                r_dac_bck_cont   <= cfg_bck_cont;
            end

            if (underrun_clr)
                r_underrun_cnt <= {{(UCNT_W - 1){1'b0}}, w_underrun};
            else if (w_underrun && !(&r_underrun_cnt))
                r_underrun_cnt <= r_underrun_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= s_if.s_data;
    end

    assign s_if.s_ready   = r_s_ready;
    assign dac_data       = r_dac_data;
    assign dac_start      = r_dac_start;
    assign dac_nos_bitnum = r_dac_nos_bitnum;
    assign dac_bck_cont   = r_dac_bck_cont;
    assign running        = r_running;
    assign underrun_cnt   = r_underrun_cnt;
    assign dbg_state      = r_state;
endmodule
